shift_queue_mp: RTL and testbench



---
 rtl/shift_queue_mp_pkg.sv | 14 +
 rtl/shift_queue_compact.sv | 33 +++
 rtl/shift_queue_mp.sv | 111 +++++++++++
 tb/tb_shift_queue_mp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_queue_mp_pkg.sv
// Shared sizing for the integer issue queue (dual dispatch, dual issue).
// Latency: n/a (constants only).
// Backpressure: n/a.
package shift_queue_mp_pkg;

    localparam int IIQ_N_ENTRIES   = 8;
    localparam int IIQ_ENTRY_WIDTH = 32;
    localparam int IIQ_N_ENQ       = 2;
    localparam int IIQ_N_DEQ       = 2;
    localparam int IIQ_CTR_WIDTH   = $clog2(IIQ_N_ENTRIES + 1);

    typedef logic [IIQ_ENTRY_WIDTH-1:0] iiq_entry_t;

endpackage

// File: rtl/shift_queue_compact.sv
// Compaction map: for each destination slot, the one-hot source slot that lands there.
// Latency: purely combinational.
// Backpressure: none.
module shift_queue_compact #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]        valid,
    input  logic [N-1:0]        remove,
    output logic [N-1:0][N-1:0] src_sel,
    output logic [CW-1:0]       surv_cnt
);

    logic [CW-1:0] rm_below;

    // A survivor at slot s drops down by the number of removed entries beneath it.
    always_comb begin
        src_sel  = '0;
        surv_cnt = '0;
        rm_below = '0;
        for (int s = 0; s < N; s++) begin
            if (valid[s] && !remove[s]) begin
                for (int d = 0; d < N; d++) begin
                    if (CW'(s) - rm_below == CW'(d)) src_sel[d][s] = 1'b1;
                end
                surv_cnt = surv_cnt + CW'(1);
            end else if (valid[s]) begin
                rm_below = rm_below + CW'(1);
            end
        end
    end

endmodule

// File: rtl/shift_queue_mp.sv
// Multi-port age-ordered collapsing queue: N_ENQ appends, N_DEQ one-hot removals per cycle.
// Latency: enqueued entries visible one edge later; deq_data is combinational from the registers.
// Backpressure: enq_ready from registered count only; dequeue is unconditional.
module shift_queue_mp
    import shift_queue_mp_pkg::*;
#(
    parameter int N_ENTRIES   = IIQ_N_ENTRIES,
    parameter int ENTRY_WIDTH = IIQ_ENTRY_WIDTH,
    parameter int N_ENQ       = IIQ_N_ENQ,
    parameter int N_DEQ       = IIQ_N_DEQ,
    parameter int CTR_WIDTH   = $clog2(N_ENTRIES + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_aH,
    input  logic                                  flush,
    output logic                                  enq_ready,
    input  logic [N_ENQ-1:0]                      enq_valid,
    input  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]     enq_data,
    input  logic [N_DEQ-1:0][N_ENTRIES-1:0]       deq_sel_onehot,
    output logic [N_DEQ-1:0]                      deq_valid,
    output logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]     deq_data,
    input  logic [N_ENTRIES-1:0]                  wr_en,
    input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] wr_data,
    output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] entry_douts,
    output logic [N_ENTRIES-1:0]                  entry_valids,
    output logic [CTR_WIDTH-1:0]                  count
);

    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] dat_q, dat_nxt, dat_wb;
    logic [N_ENTRIES-1:0]                  vld_q, vld_nxt, remove;
    logic [N_ENTRIES-1:0][N_ENTRIES-1:0]   src_sel;
    logic [CTR_WIDTH-1:0]                  cnt_q, cnt_nxt, surv_cnt, acc_cnt;
    logic [N_ENQ-1:0]                      acc;

    assign enq_ready    = (CTR_WIDTH'(N_ENTRIES) - cnt_q) >= CTR_WIDTH'(N_ENQ);
    assign acc          = enq_valid & {N_ENQ{enq_ready}};
    assign entry_douts  = dat_q;
    assign entry_valids = vld_q;
    assign count        = cnt_q;

    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        remove    = '0;
        for (int p = 0; p < N_DEQ; p++) begin
            deq_valid[p] = |(deq_sel_onehot[p] & vld_q);
            remove       = remove | (deq_sel_onehot[p] & vld_q);
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (deq_sel_onehot[p][i]) deq_data[p] = deq_data[p] | dat_q[i];
            end
        end
    end

    shift_queue_compact #(.N(N_ENTRIES), .CW(CTR_WIDTH)) u_compact (
        .valid    (vld_q),
        .remove   (remove),
        .src_sel  (src_sel),
        .surv_cnt (surv_cnt)
    );

    // Write-back applies before the move; removed entries never reach a destination,
    // so a write to a dequeued or invalid slot is dropped for free.
    always_comb begin
        acc_cnt = '0;
        for (int l = 0; l < N_ENQ; l++) begin
            if (acc[l]) acc_cnt = acc_cnt + CTR_WIDTH'(1);
        end
        cnt_nxt = surv_cnt + acc_cnt;
        for (int i = 0; i < N_ENTRIES; i++) begin
            dat_wb[i] = wr_en[i] ? wr_data[i] : dat_q[i];
        end
        for (int d = 0; d < N_ENTRIES; d++) begin
            dat_nxt[d] = dat_q[d];
            vld_nxt[d] = CTR_WIDTH'(d) < cnt_nxt;
            for (int s = 0; s < N_ENTRIES; s++) begin
                if (src_sel[d][s]) dat_nxt[d] = dat_wb[s];
            end
            for (int l = 0; l < N_ENQ; l++) begin
                if (acc[l] && CTR_WIDTH'(d) == surv_cnt + CTR_WIDTH'(l)) dat_nxt[d] = enq_data[l];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            dat_q <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            dat_q <= dat_nxt;
            vld_q <= vld_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    a_enq_contig: assert property (@(posedge clk) disable iff (rst_aH)
        ((enq_valid + N_ENQ'(1)) & enq_valid) == '0);

    for (genvar p = 0; p < N_DEQ; p++) begin : g_sel_chk
        a_sel_onehot: assert property (@(posedge clk) disable iff (rst_aH)
            $onehot0(deq_sel_onehot[p]));
        for (genvar q = p + 1; q < N_DEQ; q++) begin : g_pair
            a_sel_disjoint: assert property (@(posedge clk) disable iff (rst_aH)
                (deq_sel_onehot[p] & deq_sel_onehot[q]) == '0);
        end
    end

endmodule

// File: tb/tb_shift_queue_mp.sv
// Bench for shift_queue_mp: directed literal cases plus randomized traffic against a queue model.
module tb_shift_queue_mp;

    localparam int NE = 8;
    localparam int W  = 32;
    localparam int NQ = 2;
    localparam int ND = 2;
    localparam int CW = 4;

    logic                 clk, rst_aH, flush, enq_ready;
    logic [NQ-1:0]        enq_valid;
    logic [NQ-1:0][W-1:0] enq_data;
    logic [ND-1:0][NE-1:0] deq_sel_onehot;
    logic [ND-1:0]        deq_valid;
    logic [ND-1:0][W-1:0] deq_data;
    logic [NE-1:0]        wr_en;
    logic [NE-1:0][W-1:0] wr_data;
    logic [NE-1:0][W-1:0] entry_douts;
    logic [NE-1:0]        entry_valids;
    logic [CW-1:0]        count;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] mq[$];

    shift_queue_mp dut (
        .clk(clk), .rst_aH(rst_aH), .flush(flush), .enq_ready(enq_ready),
        .enq_valid(enq_valid), .enq_data(enq_data), .deq_sel_onehot(deq_sel_onehot),
        .deq_valid(deq_valid), .deq_data(deq_data), .wr_en(wr_en), .wr_data(wr_data),
        .entry_douts(entry_douts), .entry_valids(entry_valids), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        flush = 1'b0; enq_valid = '0; enq_data = '0;
        deq_sel_onehot = '0; wr_en = '0; wr_data = '0;
    endtask

    // Compare every DUT output against the model queue.
    task automatic compare();
        int sz;
        logic ev, known;
        logic [W-1:0] ed;
        sz = mq.size();
        chk("count", 32'(count), 32'(sz));
        chk("enq_ready", 32'(enq_ready), 32'((NE - sz) >= NQ));
        for (int i = 0; i < NE; i++) begin
            chk($sformatf("valid[%0d]", i), 32'(entry_valids[i]), 32'(i < sz));
            if (i < sz) chk($sformatf("dout[%0d]", i), entry_douts[i], mq[i]);
        end
        for (int p = 0; p < ND; p++) begin
            ev = 1'b0; ed = '0; known = 1'b1;
            for (int i = 0; i < NE; i++) begin
                if (deq_sel_onehot[p][i]) begin
                    if (i < sz) begin ev = 1'b1; ed = mq[i]; end
                    else known = 1'b0;
                end
            end
            chk($sformatf("deq_valid[%0d]", p), 32'(deq_valid[p]), 32'(ev));
            if (known) chk($sformatf("deq_data[%0d]", p), deq_data[p], ed);
        end
    endtask

    // Queue semantics: write in place, drop dequeued entries, keep order, append lanes.
    task automatic model_update();
        logic [W-1:0] nq[$];
        logic hit;
        int sz;
        sz = mq.size();
        if (flush) begin
            mq.delete();
            return;
        end
        for (int i = 0; i < sz; i++) begin
            hit = 1'b0;
            for (int p = 0; p < ND; p++) if (deq_sel_onehot[p][i]) hit = 1'b1;
            if (!hit) nq.push_back(wr_en[i] ? wr_data[i] : mq[i]);
        end
        if ((NE - sz) >= NQ) begin
            for (int l = 0; l < NQ; l++) if (enq_valid[l]) nq.push_back(enq_data[l]);
        end
        mq = nq;
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_aH = 1'b1;
        mq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_valids", 32'(entry_valids), 0);
        chk("rst_douts_or", 32'(|entry_douts), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_deq_valid", 32'(deq_valid), 0);
        chk("rst_deq_data_or", 32'(|deq_data), 0);
        rst_aH = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic enq2(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1);
        idle();
        enq_valid = v; enq_data[0] = d0; enq_data[1] = d1;
        tick();
        idle();
        #1;
    endtask

    task automatic rand_inputs();
        int i0, i1;
        flush = ($urandom_range(0, 49) == 0);
        case ($urandom_range(0, 3))
            0:       enq_valid = 2'b00;
            1:       enq_valid = 2'b01;
            default: enq_valid = 2'b11;
        endcase
        enq_data[0] = $urandom; enq_data[1] = $urandom;
        deq_sel_onehot = '0;
        i0 = $urandom_range(0, NE - 1);
        i1 = (i0 + $urandom_range(1, NE - 1)) % NE;
        if ($urandom_range(0, 2) != 0) deq_sel_onehot[0][i0] = 1'b1;
        if ($urandom_range(0, 2) != 0) deq_sel_onehot[1][i1] = 1'b1;
        wr_en = 8'($urandom & $urandom);
        for (int i = 0; i < NE; i++) wr_data[i] = $urandom;
    endtask

    initial begin
        rst_aH = 1'b1;
        idle();
        do_reset();

        // Two-lane enqueue lands in order.
        enq2(2'b11, 32'hA0, 32'hA1);
        chk("t1_count", 32'(count), 2);
        chk("t1_d0", entry_douts[0], 32'hA0);
        chk("t1_d1", entry_douts[1], 32'hA1);
        chk("t1_valids", 32'(entry_valids), 32'h03);
        chk("t1_ready", 32'(enq_ready), 1);

        // Seven entries leave room for only one: bundle refused.
        enq2(2'b11, 32'hA2, 32'hA3);
        enq2(2'b11, 32'hA4, 32'hA5);
        enq2(2'b01, 32'hA6, 32'h0);
        chk("t2_count", 32'(count), 7);
        chk("t2_ready", 32'(enq_ready), 0);
        enq2(2'b01, 32'hFF, 32'h0);
        chk("t2_count_hold", 32'(count), 7);
        chk("t2_d6", entry_douts[6], 32'hA6);

        // Dual dequeue with compaction.
        do_reset();
        enq2(2'b11, 32'hA0, 32'hA1);
        enq2(2'b11, 32'hA2, 32'hA3);
        enq2(2'b11, 32'hA4, 32'hA5);
        deq_sel_onehot[0] = 8'h02; deq_sel_onehot[1] = 8'h10;
        #1;
        chk("t3_deq0", deq_data[0], 32'hA1);
        chk("t3_deq1", deq_data[1], 32'hA4);
        chk("t3_deqv", 32'(deq_valid), 32'h3);
        tick();
        idle(); #1;
        chk("t3_count", 32'(count), 4);
        chk("t3_d0", entry_douts[0], 32'hA0);
        chk("t3_d1", entry_douts[1], 32'hA2);
        chk("t3_d2", entry_douts[2], 32'hA3);
        chk("t3_d3", entry_douts[3], 32'hA5);

        // Dequeue, write-back and enqueue together.
        deq_sel_onehot[0] = 8'h01;
        wr_en = 8'h04; wr_data[2] = 32'hBB;
        enq_valid = 2'b01; enq_data[0] = 32'hC0;
        tick();
        idle(); #1;
        chk("t4_count", 32'(count), 4);
        chk("t4_d0", entry_douts[0], 32'hA2);
        chk("t4_d1", entry_douts[1], 32'hBB);
        chk("t4_d2", entry_douts[2], 32'hA5);
        chk("t4_d3", entry_douts[3], 32'hC0);

        // Dequeue beats write on the same entry.
        do_reset();
        enq2(2'b11, 32'hA0, 32'hA1);
        enq2(2'b01, 32'hA2, 32'h0);
        wr_en = 8'h02; wr_data[1] = 32'h55;
        deq_sel_onehot[0] = 8'h02;
        #1;
        chk("t5_deq0", deq_data[0], 32'hA1);
        tick();
        idle(); #1;
        chk("t5_count", 32'(count), 2);
        chk("t5_d0", entry_douts[0], 32'hA0);
        chk("t5_d1", entry_douts[1], 32'hA2);

        // Flush wins over enqueue; async reset clears without an edge.
        do_reset();
        enq2(2'b11, 32'h1, 32'h2);
        enq2(2'b11, 32'h3, 32'h4);
        enq2(2'b01, 32'h5, 32'h0);
        flush = 1'b1; enq_valid = 2'b11;
        tick();
        idle(); #1;
        chk("t6_count", 32'(count), 0);
        chk("t6_valids", 32'(entry_valids), 0);
        chk("t6_ready", 32'(enq_ready), 1);
        enq2(2'b11, 32'hD0, 32'hD1);
        enq2(2'b11, 32'hD2, 32'hD3);
        rst_aH = 1'b1;
        #1;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_valids", 32'(entry_valids), 0);
        chk("t6_rst_douts_or", 32'(|entry_douts), 0);
        mq.delete();
        @(negedge clk);
        rst_aH = 1'b0;
        @(posedge clk);
        #1;

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            rand_inputs();
            tick();
        end
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
